fft8_bf_sched: RTL and testbench
================================

// Module: fft8_bf_sched
// PURPOSE
//  Sequencer for one shared radix-2 butterfly datapath, computing an 8-point DIT FFT in place.
//  - Owns an 8 x 24-bit sample buffer.
//  - Loads a frame through a valid/ready stream, storing it in bit-reversed order.
//  - Issues 12 butterflies (3 stages x 4), one per cycle, and writes results back in place.
//  - Streams the spectrum out in natural order.
//  - Sits between the sample source and the spectrum consumer; the butterfly and twiddle multiplier are external.
// PARAMETERS
//  DATA_W  24  complex word {re[DATA_W-1:DATA_W/2], im[DATA_W/2-1:0]}, each half 2's-complement signed
//  N_PT    8   FFT length; fixed at 8; any other value is a synthesis error
// PORTS
//  clk       in   1       sole clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  in_valid  in   1       input sample valid
//  in_ready  out  1       block accepts a sample (state LOAD)
//  in_data   in   DATA_W  input sample x[n], presented in order n = 0..7
//  out_valid out  1       output bin valid
//  out_ready in   1       consumer accepts a bin
//  out_data  out  DATA_W  spectrum bin X[k], k = 0..7
//  out_last  out  1       high with X[7]
//  bf_a      out  DATA_W  butterfly top operand (buf[top])
//  bf_b      out  DATA_W  butterfly bottom operand (buf[bot]); goes to the external twiddle multiplier
//  tw_idx    out  2       twiddle exponent e; the datapath uses W8^e
//  bf_c1     in   DATA_W  (A + W*B)/2 from the datapath, combinational, same cycle
//  bf_c2     in   DATA_W  (A - W*B)/2 from the datapath, combinational, same cycle
//  busy      out  1       high in RUN or UNLOAD
// BEHAVIOUR
//  - FSM states: LOAD -> RUN -> UNLOAD -> LOAD. There is no idle state.
//  - Reset (asynchronous, any state, including mid-RUN/UNLOAD):
//    - state = LOAD; in_cnt, stg, bfc and out_cnt = 0.
//    - Outputs: in_ready=1, out_valid=0, out_last=0, busy=0, bf_a=0, bf_b=0, tw_idx=0.
//    - Buffer contents are not cleared; they are don't-care.
//    - Any partial frame is discarded.
//  - LOAD:
//    - in_ready=1.
//    - On in_valid&in_ready: buf[bitrev3(in_cnt)] <= in_data; in_cnt++.
//    - After the 8th accept: in_cnt wraps to 0 and the next state is RUN.
//  - RUN: 12 cycles, stg = 0..2 (outer), bfc = 0..3 (inner).
//    - span = 1<<stg; j = bfc & (span-1); top = ((bfc>>stg)<<(stg+1)) + j; bot = top + span; tw_idx = j << (2-stg).
//    - bf_a/bf_b are combinational reads of buf[top]/buf[bot].
//    - Each cycle, at the clock edge: buf[top] <= bf_c1; buf[bot] <= bf_c2.
//    - After stg=2, bfc=3, the next state is UNLOAD.
//    - Outside RUN: bf_a = bf_b = 0 and tw_idx = 0.
//  - Stage schedule (top,bot:tw):
//    - s0: (0,1:0) (2,3:0) (4,5:0) (6,7:0)
//    - s1: (0,2:0) (1,3:2) (4,6:0) (5,7:2)
//    - s2: (0,4:0) (1,5:1) (2,6:2) (3,7:3)
//  - UNLOAD:
//    - out_valid=1; out_data = buf[out_cnt]; out_last = (out_cnt==7).
//    - out_cnt advances only on out_valid&out_ready.
//    - out_data and out_last hold stable while out_ready=0.
//    - After the 8th transfer, the next state is LOAD.
//  - Latency: 8th input accept at edge T -> RUN during cycles T+1..T+12 -> out_valid=1 from cycle T+13.
//    - In-to-out minimum is 13 cycles.
//    - Throughput: 28 cycles per frame at full handshake rate.
//  - Inputs are not accepted during RUN or UNLOAD: in_ready=0, no double buffering.
//  - Scaling: the datapath halves each stage, so the output is X[k]/8. The block does no arithmetic itself.
// STRUCTURE
//  - Package fft8_pkg:
//    - constants N_PT=8, LOG2N=3, DATA_W=24;
//    - state enum {LOAD, RUN, UNLOAD};
//    - function bitrev3.
//  - Sub-module fft8_addr_gen: combinational map (stg, bfc) -> (top, bot, tw_idx).
//  - Top holds the FSM, the counters, the buffer, and the read/write muxing.
// TESTING
//  1. Schedule check: any frame -> per RUN cycle, the (top,bot,tw_idx) sequence equals the table above, exactly 12 cycles.
//  2. Bit-reversal check: load x[n] = {n,0} -> first RUN cycle shows bf_a={0,0}, bf_b={4,0}; second shows {2,0},{6,0}.
//  3. Impulse: x[0]={256,0}, others 0, with a reference butterfly model -> all X[k]={32,0}; out_last only on k=7.
//  4. DC: all x={256,0} -> X[0]={256,0}, X[1..7]={0,0}. First out_valid occurs 13 cycles after the 8th accept.
//  5. Backpressure: out_ready=0 for 3 cycles while X[2] is presented -> out_data stays X[2] and in_ready stays 0.
//  6. Reset during RUN, then reset mid-UNLOAD -> outputs go immediately to reset values; a next clean frame gives correct results; back-to-back frames stream correctly.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point in-place FFT butterfly sequencer.
//   N_PT   : FFT length (fixed at 8)
//   LOG2N  : number of radix-2 stages
//   DATA_W : complex word width {re, im}, each half 2's-complement
package fft8_pkg;

  localparam int unsigned N_PT   = 8;
  localparam int unsigned LOG2N  = 3;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned TW_W   = 2;

  // Complex sample: real part in the upper half, imaginary in the lower half
  typedef struct packed {
    logic [HALF_W-1:0] re;
    logic [HALF_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  // Reverse the three index bits (input order -> DIT storage order)
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft8_bf_sched_if.sv
// Stream and butterfly-datapath bundle for fft8_bf_sched.
//   in_*   : sample input stream (valid/ready)
//   out_*  : spectrum output stream (valid/ready, last on X[7])
//   bf_*   : operands to / results from the external butterfly datapath
//   tw_idx : twiddle exponent e, datapath uses W8^e
//   busy   : block is in RUN or UNLOAD
// slave modport is the sequencer side, master is the source/consumer/datapath side.
interface fft8_bf_sched_if;
  import fft8_pkg::*;

  logic                in_valid;
  logic                in_ready;
  cplx_t               in_data;
  logic                out_valid;
  logic                out_ready;
  cplx_t               out_data;
  logic                out_last;
  cplx_t               bf_a;
  cplx_t               bf_b;
  logic [TW_W-1:0]     tw_idx;
  cplx_t               bf_c1;
  cplx_t               bf_c2;
  logic                busy;

  modport slave (
    input  in_valid, in_data, out_ready, bf_c1, bf_c2,
    output in_ready, out_valid, out_data, out_last, bf_a, bf_b, tw_idx, busy
  );

  modport master (
    output in_valid, in_data, out_ready, bf_c1, bf_c2,
    input  in_ready, out_valid, out_data, out_last, bf_a, bf_b, tw_idx, busy
  );

endinterface

// File: rtl/fft8_addr_gen.sv
// Butterfly address generator: maps (stage, butterfly index) to the in-place
// top/bottom buffer addresses and the twiddle exponent.
//   i_stg     : stage 0..2
//   i_bfc     : butterfly within stage 0..3
//   o_top_c   : top operand address
//   o_bot_c   : bottom operand address (top + 2^stg)
//   o_tw_c    : twiddle exponent (j << (2-stg), j = bfc mod 2^stg)
module fft8_addr_gen
  import fft8_pkg::*;
(
  input  logic [1:0]       i_stg,
  input  logic [1:0]       i_bfc,
  output logic [LOG2N-1:0] o_top_c,
  output logic [LOG2N-1:0] o_bot_c,
  output logic [TW_W-1:0]  o_tw_c
);

  // Closed form of the general shift/mask expressions for each of the 3 stages
  always_comb begin
    o_top_c = '0;
    o_bot_c = '0;
    o_tw_c  = '0;
    unique case (i_stg)
      2'd0: begin
        o_top_c = {i_bfc, 1'b0};
        o_bot_c = {i_bfc, 1'b1};
        o_tw_c  = 2'd0;
      end
      2'd1: begin
        o_top_c = {i_bfc[1], 1'b0, i_bfc[0]};
        o_bot_c = {i_bfc[1], 1'b1, i_bfc[0]};
        o_tw_c  = {i_bfc[0], 1'b0};
      end
      2'd2: begin
        o_top_c = {1'b0, i_bfc};
        o_bot_c = {1'b1, i_bfc};
        o_tw_c  = i_bfc;
      end
      default: begin
        o_top_c = '0;
        o_bot_c = '0;
        o_tw_c  = '0;
      end
    endcase
  end

endmodule

// File: rtl/fft8_bf_sched.sv
// Sequencer for one shared radix-2 butterfly: loads an 8-sample frame in
// bit-reversed order, issues 12 in-place butterflies (one per cycle) to an
// external datapath, then streams the spectrum out in natural order.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   io_bus : stream + datapath bundle (slave side)
module fft8_bf_sched #(
  parameter int unsigned DATA_W = fft8_pkg::DATA_W,
  parameter int unsigned N_PT   = fft8_pkg::N_PT
) (
  input  logic               clk,
  input  logic               rst,
  fft8_bf_sched_if.slave     io_bus
);
  import fft8_pkg::cplx_t;
  import fft8_pkg::state_t;
  import fft8_pkg::ST_LOAD;
  import fft8_pkg::ST_RUN;
  import fft8_pkg::ST_UNLOAD;
  import fft8_pkg::bitrev3;

  localparam int unsigned AW    = fft8_pkg::LOG2N;
  localparam int unsigned DEPTH = fft8_pkg::N_PT;

  // Only the 8-point, 24-bit configuration is supported
  if (N_PT != 8 || DATA_W != fft8_pkg::DATA_W) begin : g_bad_cfg
    $error("fft8_bf_sched: only N_PT=8, DATA_W=24 supported");
  end

  state_t          r_state;
  logic [AW-1:0]   r_in_cnt;
  logic [AW-1:0]   r_out_cnt;
  logic [1:0]      r_stg;
  logic [1:0]      r_bfc;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_busy;
  cplx_t           r_buf [DEPTH];

  logic            w_accept;
  logic            w_xfer;
  logic            w_run;
  logic [AW-1:0]   w_top;
  logic [AW-1:0]   w_bot;
  logic [1:0]      w_tw;

  assign w_accept = io_bus.in_valid  & r_in_ready;
  assign w_xfer   = r_out_valid      & io_bus.out_ready;
  assign w_run    = (r_state == ST_RUN);

  fft8_addr_gen u_addr_gen (
    .i_stg   (r_stg),
    .i_bfc   (r_bfc),
    .o_top_c (w_top),
    .o_bot_c (w_bot),
    .o_tw_c  (w_tw)
  );

  // FSM, counters and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_stg       <= '0;
      r_bfc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_in_cnt <= r_in_cnt + AW'(1);
            if (r_in_cnt == AW'(DEPTH - 1)) begin
              r_state    <= ST_RUN;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_bfc <= r_bfc + 2'd1;
          if (r_bfc == 2'd3) begin
            if (r_stg == 2'd2) begin
              r_stg       <= '0;
              r_state     <= ST_UNLOAD;
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
            end else begin
              r_stg <= r_stg + 2'd1;
            end
          end
        end
        ST_UNLOAD: begin
          if (w_xfer) begin
            r_out_cnt  <= r_out_cnt + AW'(1);
            // out_last must already be high while X[7] is presented
            r_out_last <= (r_out_cnt == AW'(DEPTH - 2));
            if (r_out_cnt == AW'(DEPTH - 1)) begin
              r_state     <= ST_LOAD;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= ST_LOAD;
          r_in_cnt    <= '0;
          r_out_cnt   <= '0;
          r_stg       <= '0;
          r_bfc       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Sample buffer: bit-reversed load, in-place butterfly write-back; never reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[bitrev3(r_in_cnt)] <= io_bus.in_data;
    end
    if (w_run) begin
      r_buf[w_top] <= io_bus.bf_c1;
      r_buf[w_bot] <= io_bus.bf_c2;
    end
  end

  // Operands and twiddle are only driven while butterflies are being issued
  assign io_bus.bf_a     = w_run ? r_buf[w_top] : '0;
  assign io_bus.bf_b     = w_run ? r_buf[w_bot] : '0;
  assign io_bus.tw_idx   = w_run ? w_tw         : '0;

  assign io_bus.out_data  = r_buf[r_out_cnt];
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_fft8_bf_sched.sv
// Bench for fft8_bf_sched: supplies a reference butterfly datapath, drives
// frames, and checks the butterfly schedule, timing and spectrum output.
module tb_fft8_bf_sched;
  import fft8_pkg::*;

  typedef logic [7:0][DATA_W-1:0] frame_t;

  typedef struct packed {
    frame_t x;
    frame_t y;
  } vec_t;

  typedef struct packed {
    cplx_t d;
    logic  last;
  } exp_t;

  logic clk;
  logic rst;
  bit   dp_pass;

  fft8_bf_sched_if bus ();

  fft8_bf_sched u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  exp_t q[$];

  int first_acc;
  int prev_first;
  bit have_prev;
  bit prev_bp;

  int sch_top [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int sch_bot [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int sch_tw  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  function automatic cplx_t mk(input int re, input int im);
    cplx_t c;
    c.re = HALF_W'(re);
    c.im = HALF_W'(im);
    return c;
  endfunction

  // Reference butterfly: c1 = (A + W8^e * B)/2, c2 = (A - W8^e * B)/2, 1/sqrt2 ~ 181/256
  function automatic void bfly(input cplx_t a, input cplx_t b, input logic [1:0] e,
                               output cplx_t c1, output cplx_t c2);
    int ar, ai, br, bi, wr, wi;
    ar = int'($signed(a.re));
    ai = int'($signed(a.im));
    br = int'($signed(b.re));
    bi = int'($signed(b.im));
    case (e)
      2'd0:    begin wr = br;                    wi = bi;                     end
      2'd1:    begin wr = ((br + bi) * 181) >>> 8; wi = ((bi - br) * 181) >>> 8;  end
      2'd2:    begin wr = bi;                    wi = -br;                    end
      default: begin wr = ((bi - br) * 181) >>> 8; wi = ((-bi - br) * 181) >>> 8; end
    endcase
    c1 = mk((ar + wr) >>> 1, (ai + wi) >>> 1);
    c2 = mk((ar - wr) >>> 1, (ai - wi) >>> 1);
  endfunction

  // External datapath model; pass mode writes operands back unchanged
  always_comb begin
    cplx_t c1, c2;
    bfly(bus.bf_a, bus.bf_b, bus.tw_idx, c1, c2);
    if (dp_pass) begin
      bus.bf_c1 = bus.bf_a;
      bus.bf_c2 = bus.bf_b;
    end else begin
      bus.bf_c1 = c1;
      bus.bf_c2 = c2;
    end
  end

  // Software in-place DIT FFT using the reference butterfly
  function automatic frame_t golden(input frame_t x, input bit pass);
    cplx_t  b [8];
    cplx_t  c1, c2;
    frame_t y;
    for (int n = 0; n < 8; n++) b[bitrev3(3'(n))] = x[n];
    if (!pass) begin
      for (int s = 0; s < 3; s++) begin
        int span = 1 << s;
        for (int g = 0; g < 8; g += 2 * span) begin
          for (int j = 0; j < span; j++) begin
            bfly(b[g + j], b[g + j + span], 2'(j * (4 >> s)), c1, c2);
            b[g + j]        = c1;
            b[g + j + span] = c2;
          end
        end
      end
    end
    for (int k = 0; k < 8; k++) y[k] = b[k];
    return y;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_frame(input frame_t y);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.d    = y[k];
      e.last = (k == 7);
      q.push_back(e);
    end
  endtask

  task automatic send_frame(input frame_t x);
    for (int n = 0; n < 8; n++) begin
      int budget = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = x[n];
      while (!bus.in_ready && budget < 64) begin
        step();
        budget++;
      end
      if (budget >= 64) chk("in_ready_timeout", 32'd0, 32'd1);
      step();
      if (n == 0) begin
        first_acc = cyc;
        if (have_prev && !prev_bp) chk("frame_period", 32'(first_acc - prev_first), 32'd28);
        prev_first = first_acc;
        have_prev  = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  // Called right after the 8th accept edge; covers ncyc RUN cycles
  task automatic run_phase(input bit chk_ops, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      chk("run_busy",      32'(bus.busy),      32'd1);
      chk("run_out_valid", 32'(bus.out_valid), 32'd0);
      chk("run_in_ready",  32'(bus.in_ready),  32'd0);
      chk("run_tw_idx",    32'(bus.tw_idx),    32'(sch_tw[c]));
      if (chk_ops) begin
        chk("run_bf_a", 32'(bus.bf_a), 32'(mk(int'(bitrev3(3'(sch_top[c]))), 0)));
        chk("run_bf_b", 32'(bus.bf_b), 32'(mk(int'(bitrev3(3'(sch_bot[c]))), 0)));
      end
      step();
    end
    // 12 edges after the 8th accept the first bin must be on the bus
    if (ncyc == 12) begin
      chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
      chk("unload_bf_a_zero",  32'(bus.bf_a),      32'd0);
    end
  endtask

  task automatic recv_frame(input int bp_at, input int nbins);
    prev_bp = (bp_at >= 0);
    for (int k = 0; k < nbins; k++) begin
      int budget = 0;
      if (k == bp_at) begin
        bus.out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
          chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
          if (q.size() > 0) begin
            chk("bp_out_data", 32'(bus.out_data), 32'(q[0].d));
            chk("bp_out_last", 32'(bus.out_last), 32'(q[0].last));
          end
          step();
        end
        bus.out_ready = 1'b1;
      end
      while (!bus.out_valid && budget < 64) begin
        step();
        budget++;
      end
      if (budget >= 64) chk("out_valid_timeout", 32'd0, 32'd1);
      if (q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        exp_t e = q.pop_front();
        chk($sformatf("out_data[%0d]", k), 32'(bus.out_data), 32'(e.d));
        chk($sformatf("out_last[%0d]", k), 32'(bus.out_last), 32'(e.last));
      end
      step();
    end
    if (nbins == 8) begin
      chk("post_unload_in_ready",  32'(bus.in_ready),  32'd1);
      chk("post_unload_out_valid", 32'(bus.out_valid), 32'd0);
      chk("post_unload_busy",      32'(bus.busy),      32'd0);
    end
  endtask

  // Assert reset asynchronously and check outputs before any clock edge
  task automatic reset_check(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_bf_a"},      32'(bus.bf_a),      32'd0);
    chk({tag, "_bf_b"},      32'(bus.bf_b),      32'd0);
    chk({tag, "_tw_idx"},    32'(bus.tw_idx),    32'd0);
    q.delete();
    have_prev = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  function automatic frame_t rand_frame();
    frame_t x;
    for (int n = 0; n < 8; n++)
      x[n] = mk(int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 500);
    return x;
  endfunction

  vec_t   tbl [4];
  frame_t fx;

  initial begin
    rst           = 1'b1;
    dp_pass       = 1'b1;
    have_prev     = 1'b0;
    prev_bp       = 1'b0;
    first_acc     = 0;
    prev_first    = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Hand-derived spectra (output is X[k]/8)
    for (int n = 0; n < 8; n++) begin
      tbl[0].x[n] = (n == 0) ? mk(256, 0) : mk(0, 0);
      tbl[0].y[n] = mk(32, 0);
      tbl[1].x[n] = mk(256, 0);
      tbl[1].y[n] = (n == 0) ? mk(256, 0) : mk(0, 0);
      tbl[2].x[n] = mk(0, 256);
      tbl[2].y[n] = (n == 0) ? mk(0, 256) : mk(0, 0);
      tbl[3].x[n] = (n % 2 == 0) ? mk(256, 0) : mk(-256, 0);
      tbl[3].y[n] = (n == 4) ? mk(256, 0) : mk(0, 0);
    end

    #2;
    reset_check("reset");

    // Schedule and bit-reversal frame: pass-through datapath keeps buf[p] = {bitrev(p),0}
    for (int n = 0; n < 8; n++) fx[n] = mk(n, 0);
    push_frame(golden(fx, 1'b1));
    send_frame(fx);
    run_phase(1'b1, 12);
    recv_frame(-1, 8);

    // Table vectors back-to-back; DC frame holds X[2] under backpressure
    dp_pass = 1'b0;
    for (int v = 0; v < 4; v++) begin
      push_frame(tbl[v].y);
      send_frame(tbl[v].x);
      run_phase(1'b0, 12);
      recv_frame((v == 1) ? 2 : -1, 8);
    end

    // Random frames against the software FFT
    for (int r = 0; r < 2; r++) begin
      fx = rand_frame();
      push_frame(golden(fx, 1'b0));
      send_frame(fx);
      run_phase(1'b0, 12);
      recv_frame(-1, 8);
    end

    // Reset in the middle of RUN, then a clean frame
    fx = rand_frame();
    push_frame(golden(fx, 1'b0));
    send_frame(fx);
    run_phase(1'b0, 5);
    reset_check("rst_run");
    push_frame(tbl[0].y);
    send_frame(tbl[0].x);
    run_phase(1'b0, 12);
    recv_frame(-1, 8);

    // Reset in the middle of UNLOAD, then a clean frame
    fx = rand_frame();
    push_frame(golden(fx, 1'b0));
    send_frame(fx);
    run_phase(1'b0, 12);
    recv_frame(-1, 3);
    reset_check("rst_unload");
    fx = rand_frame();
    push_frame(golden(fx, 1'b0));
    send_frame(fx);
    run_phase(1'b0, 12);
    recv_frame(-1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
